map_index_to_display_pos: RTL and testbench

Inverse of the display-position-to-matrix-index mapping. Accepts one game-matrix cell index (80x50 grid) over a valid/ready handshake. Streams the display pixel coordinates covering that cell's 16x16 block, in raster order, over a second valid/ready handshake. Also provides the block's centre pixel. The tile renderer uses it to paint a cell into the 1280x800 visible area.

---
 rtl/map_index_to_display_pos_if.sv | 26 ++
 rtl/map_index_to_display_pos.sv | 148 ++++++++++++++
 tb/tb_map_index_to_display_pos.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/map_index_to_display_pos_if.sv
// Handshake bundle for the cell-index to display-pixel mapper: one request
// channel (cell index in) and one stream channel (pixel coordinates out).
interface map_index_to_display_pos_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_idx_x;
  logic [5:0]  in_idx_y;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        out_last;
  logic [10:0] center_x;
  logic [9:0]  center_y;
  logic        idx_err;

  modport master (
    output in_valid, in_idx_x, in_idx_y, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_last, center_x, center_y, idx_err
  );

  modport slave (
    input  in_valid, in_idx_x, in_idx_y, out_ready,
    output in_ready, out_valid, out_x, out_y, out_last, center_x, center_y, idx_err
  );
endinterface

// File: rtl/map_index_to_display_pos.sv
// Expands one matrix cell index into the raster-ordered pixel coordinates of
// its square tile, plus the tile centre pixel, for the tile renderer.
module map_index_to_display_pos #(
  parameter int MAT_W           = 80,
  parameter int MAT_H           = 50,
  parameter int TILE_SHIFT      = 4,
  parameter int MOVE_TO_CENTER  = 7,
  parameter int H_VISIBLE_START = 0,
  parameter int V_VISIBLE_START = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  map_index_to_display_pos_if.slave  bus
);

  localparam logic [6:0]            MAT_W_C   = 7'(MAT_W);
  localparam logic [5:0]            MAT_H_C   = 6'(MAT_H);
  localparam logic [10:0]           H_START_C = 11'(H_VISIBLE_START);
  localparam logic [9:0]            V_START_C = 10'(V_VISIBLE_START);
  localparam logic [10:0]           MOVE_X_C  = 11'(MOVE_TO_CENTER);
  localparam logic [9:0]            MOVE_Y_C  = 10'(MOVE_TO_CENTER);
  localparam logic [TILE_SHIFT-1:0] TILE_MAX  = {TILE_SHIFT{1'b1}};
  localparam logic [TILE_SHIFT-1:0] TILE_ZERO = {TILE_SHIFT{1'b0}};
  localparam logic [TILE_SHIFT-1:0] TILE_ONE  = {{(TILE_SHIFT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [TILE_SHIFT-1:0] col_r, col_s, row_r, row_s;
  logic [10:0]           base_x_r, base_x_s, out_x_r, out_x_s, center_x_r, center_x_s;
  logic [9:0]            base_y_r, base_y_s, out_y_r, out_y_s, center_y_r, center_y_s;
  logic                  out_last_r, out_last_s;
  logic                  idx_err_r, idx_err_s;
  logic                  in_ready_r, out_valid_r;
  logic                  idx_bad_s;

  assign idx_bad_s = (bus.in_idx_x >= MAT_W_C) || (bus.in_idx_y >= MAT_H_C);

  // Next-state and next-output computation; outputs are registered below.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    row_s      = row_r;
    base_x_s   = base_x_r;
    base_y_s   = base_y_r;
    out_x_s    = out_x_r;
    out_y_s    = out_y_r;
    out_last_s = out_last_r;
    center_x_s = center_x_r;
    center_y_s = center_y_r;
    idx_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (idx_bad_s) begin
            idx_err_s = 1'b1;
          end else begin
            base_x_s   = H_START_C + (11'(bus.in_idx_x) << TILE_SHIFT);
            base_y_s   = V_START_C + (10'(bus.in_idx_y) << TILE_SHIFT);
            col_s      = TILE_ZERO;
            row_s      = TILE_ZERO;
            out_x_s    = base_x_s;
            out_y_s    = base_y_s;
            out_last_s = 1'b0;
            center_x_s = base_x_s + MOVE_X_C;
            center_y_s = base_y_s + MOVE_Y_C;
            state_s    = ST_STREAM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (bus.out_ready) begin
          if (out_last_r) begin
            state_s    = ST_IDLE;
            col_s      = TILE_ZERO;
            row_s      = TILE_ZERO;
            out_last_s = 1'b0;
          end else begin
            // Column counter wraps naturally; row advances on the wrap.
            col_s = col_r + TILE_ONE;
            if (col_r == TILE_MAX) begin
              row_s = row_r + TILE_ONE;
            end else begin
              row_s = row_r;
            end
            out_x_s    = base_x_r + 11'(col_s);
            out_y_s    = base_y_r + 10'(row_s);
            out_last_s = (col_s == TILE_MAX) && (row_s == TILE_MAX);
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        idx_err_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      col_r       <= TILE_ZERO;
      row_r       <= TILE_ZERO;
      base_x_r    <= 11'd0;
      base_y_r    <= 10'd0;
      out_x_r     <= 11'd0;
      out_y_r     <= 10'd0;
      out_last_r  <= 1'b0;
      center_x_r  <= 11'd0;
      center_y_r  <= 10'd0;
      idx_err_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      row_r       <= row_s;
      base_x_r    <= base_x_s;
      base_y_r    <= base_y_s;
      out_x_r     <= out_x_s;
      out_y_r     <= out_y_s;
      out_last_r  <= out_last_s;
      center_x_r  <= center_x_s;
      center_y_r  <= center_y_s;
      idx_err_r   <= idx_err_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_STREAM);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_x     = out_x_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_last  = out_last_r;
  assign bus.center_x  = center_x_r;
  assign bus.center_y  = center_y_r;
  assign bus.idx_err   = idx_err_r;

endmodule

// File: tb/tb_map_index_to_display_pos.sv
// Randomised and directed bench: a beat-queue model predicts every output
// each cycle; a small table of hand-computed coordinates pins the model.
module tb_map_index_to_display_pos;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  map_index_to_display_pos_if bus ();

  map_index_to_display_pos dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_cx = 0, exp_cy = 0;
  bit    exp_err = 1'b0;
  bit    zero_chk = 1'b0;
  bit    started = 1'b0;
  int    acc_cnt = 0;
  int    cur_test = 0;
  int    rmode = 0;
  int    n_chk = 0, n_pass = 0, n_prints = 0;

  // {test, beat number, x, y} read off the tile geometry by hand
  localparam int PIN[8][4] = '{
    '{1, 1, 0, 0}, '{1, 16, 15, 0}, '{1, 17, 0, 1}, '{1, 256, 15, 15},
    '{2, 1, 1264, 784}, '{2, 256, 1279, 799},
    '{3, 17, 48, 33}, '{5, 1, 16, 16}
  };
  localparam int CPIN[2][3] = '{'{1, 7, 7}, '{2, 1271, 791}};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else if (n_prints < 40) begin
      n_prints++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    $display("FAIL timeout_%s: still pending, expected completion (t=%0t)", nm, $time);
  endtask

  // Reference model: a request becomes 256 queued beats; a transfer pops one.
  initial begin
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst_n) begin
        exp_q.delete();
        exp_err  = 1'b0;
        exp_cx   = 0;
        exp_cy   = 0;
        zero_chk = 1'b1;
      end else begin
        zero_chk = 1'b0;
        exp_err  = 1'b0;
        if (exp_q.size() != 0) begin
          if (bus.out_ready) void'(exp_q.pop_front());
        end else if (bus.in_valid) begin
          acc_cnt++;
          if (int'(bus.in_idx_x) >= 80 || int'(bus.in_idx_y) >= 50) begin
            exp_err = 1'b1;
          end else begin
            int bx, by;
            bx = int'(bus.in_idx_x) * 16;
            by = int'(bus.in_idx_y) * 16;
            exp_cx = bx + 7;
            exp_cy = by + 7;
            for (int r = 0; r < 16; r++)
              for (int c = 0; c < 16; c++)
                exp_q.push_back('{bx + c, by + r, (r == 15) && (c == 15)});
          end
        end
      end
    end
  end

  // Compare process, sampling mid-low-phase after all inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        chk("in_ready", int'(bus.in_ready), int'(exp_q.size() == 0));
        chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
        chk("idx_err", int'(bus.idx_err), int'(exp_err));
        chk("center_x", int'(bus.center_x), exp_cx);
        chk("center_y", int'(bus.center_y), exp_cy);
        if (exp_q.size() != 0) begin
          chk("out_x", int'(bus.out_x), exp_q[0].x);
          chk("out_y", int'(bus.out_y), exp_q[0].y);
          chk("out_last", int'(bus.out_last), int'(exp_q[0].last));
          if (bus.out_ready) begin
            int bn;
            bn = 257 - exp_q.size();
            for (int i = 0; i < 8; i++) begin
              if (PIN[i][0] == cur_test && PIN[i][1] == bn) begin
                chk("pin_x", int'(bus.out_x), PIN[i][2]);
                chk("pin_y", int'(bus.out_y), PIN[i][3]);
              end
            end
            for (int i = 0; i < 2; i++) begin
              if (CPIN[i][0] == cur_test && bn == 1) begin
                chk("pin_center_x", int'(bus.center_x), CPIN[i][1]);
                chk("pin_center_y", int'(bus.center_y), CPIN[i][2]);
              end
            end
          end
        end
        if (zero_chk) begin
          chk("reset_out_x", int'(bus.out_x), 0);
          chk("reset_out_y", int'(bus.out_y), 0);
          chk("reset_out_last", int'(bus.out_last), 0);
        end
      end
    end
  end

  // Consumer backpressure: always ready, fixed 1,0,0,1 pattern, or random.
  initial begin
    int k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  task automatic send(input int x, input int y, input bit hold);
    int a0;
    a0 = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_idx_x = 7'(x);
    bus.in_idx_y = 6'(y);
    for (int i = 0; i < 3000 && acc_cnt == a0; i++) @(negedge clk);
    if (acc_cnt == a0) timeout_fail("accept");
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) timeout_fail("idle");
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_idx_x = 7'd0;
    bus.in_idx_y = 6'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cur_test = 1; send(0, 0, 1'b0);   wait_idle(2000);
    cur_test = 2; send(79, 49, 1'b0); wait_idle(2000);
    cur_test = 3; rmode = 1; send(3, 2, 1'b0); wait_idle(4000); rmode = 0;
    cur_test = 4; send(80, 0, 1'b0); @(negedge clk); send(0, 50, 1'b0);
    repeat (2) @(negedge clk);

    // Abort a stream after 100 transferred beats.
    cur_test = 0; send(0, 0, 1'b0);
    for (int i = 0; i < 1000 && exp_q.size() > 156; i++) @(negedge clk);
    chk("abort_point", exp_q.size(), 156);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_test = 5; send(1, 1, 1'b0); wait_idle(2000);

    // Back-to-back requests with in_valid held high throughout.
    cur_test = 6; send(5, 5, 1'b1); send(6, 6, 1'b0); wait_idle(4000);

    cur_test = 7; rmode = 2;
    repeat (24) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(int'($urandom_range(0, 85)), int'($urandom_range(0, 55)), 1'b0);
    end
    wait_idle(4000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
